// File: rtl/shift_reg_n.sv
// Multi-mode shift register with a start/busy/done handshake.
// LOAD/CLEAR/NOP take one cycle; shifts and rotates step one position per clock.
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_LOAD  = 3'd0;
    localparam logic [2:0] M_SHL   = 3'd1;
    localparam logic [2:0] M_SHR   = 3'd2;
    localparam logic [2:0] M_ROL   = 3'd3;
    localparam logic [2:0] M_ROR   = 3'd4;
    localparam logic [2:0] M_ASR   = 3'd5;
    localparam logic [2:0] M_CLEAR = 3'd6;
    localparam logic [2:0] M_NOP   = 3'd7;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_ser_out;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shift_q;
    logic             w_shift_out;

    // One-position result for the latched mode
    always_comb begin
        w_shift_q   = r_q;
        w_shift_out = r_ser_out;
        unique case (r_mode)
            M_SHL: begin
                w_shift_q   = {r_q[WIDTH-2:0], ser_in};
                w_shift_out = r_q[WIDTH-1];
            end
            M_SHR: begin
                w_shift_q   = {ser_in, r_q[WIDTH-1:1]};
                w_shift_out = r_q[0];
            end
            M_ROL: begin
                w_shift_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_shift_out = r_q[WIDTH-1];
            end
            M_ROR: begin
                w_shift_q   = {r_q[0], r_q[WIDTH-1:1]};
                w_shift_out = r_q[0];
            end
            M_ASR: begin
                w_shift_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_shift_out = r_q[0];
            end
            default: begin
                w_shift_q   = r_q;
                w_shift_out = r_ser_out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= M_NOP;
            r_cnt     <= '0;
            r_q       <= '0;
            r_ser_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        unique case (mode)
                            M_LOAD: begin
                                r_q    <= d;
                                r_done <= 1'b1;
                            end
                            M_CLEAR: begin
                                r_q    <= '0;
                                r_done <= 1'b1;
                            end
                            M_NOP: begin
                                r_done <= 1'b1;
                            end
                            default: begin
                                r_mode  <= mode;
                                r_cnt   <= amount;
                                r_busy  <= 1'b1;
                                r_state <= S_SHIFT;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    // A zero count finishes without touching q
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_q       <= w_shift_q;
                        r_ser_out <= w_shift_out;
                        r_cnt     <= r_cnt - AMT_W'(1);
                        if (r_cnt == AMT_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q       = r_q;
    assign ser_out = r_ser_out;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n: commands push expected {q, ser_out},
// a monitor pops and compares on every done pulse.
module tb_shift_reg_n;

    localparam logic [2:0] LOAD  = 3'd0;
    localparam logic [2:0] SHL   = 3'd1;
    localparam logic [2:0] SHR   = 3'd2;
    localparam logic [2:0] ROL   = 3'd3;
    localparam logic [2:0] ROR   = 3'd4;
    localparam logic [2:0] ASR   = 3'd5;
    localparam logic [2:0] CLEAR = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic [3:0] amount = 4'd0;
    logic       ser_in = 1'b0;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_e;

    logic [7:0] seq_q [3] = '{8'h4B, 8'h97, 8'h2F};
    logic       seq_so[3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    shift_reg_n #(.WIDTH(8), .AMT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .d      (d),
        .amount (amount),
        .ser_in (ser_in),
        .q      (q),
        .ser_out(ser_out),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no pending command");
            end else begin
                mon_e = sb.pop_front();
                chk("done_q", {24'd0, q}, {24'd0, mon_e[8:1]});
                chk("done_ser_out", {31'd0, ser_out}, {31'd0, mon_e[0]});
            end
        end
    end

    // Drive one start strobe; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] m, input logic [7:0] dv,
                         input logic [3:0] amt, input logic si,
                         input logic [8:0] exp, input bit push);
        if (push) sb.push_back(exp);
        start  = 1'b1;
        mode   = m;
        d      = dv;
        amount = amt;
        ser_in = si;
        @(negedge clk);
        start = 1'b0;
        mode  = 3'd7;
        d     = 8'h00;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    endtask

    initial begin
        // Reset with a competing LOAD strobe
        rst   = 1'b0;
        start = 1'b1;
        mode  = LOAD;
        d     = 8'hFF;
        repeat (2) @(negedge clk);
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        issue(LOAD, 8'hA5, 4'd0, 1'b0, {8'hA5, 1'b0}, 1'b1);
        chk("load_busy", {31'd0, busy}, 32'd0);
        wait_done("load");
        @(negedge clk);
        chk("load_done_pulse", {31'd0, done}, 32'd0);

        issue(SHL, 8'h00, 4'd3, 1'b1, {8'h2F, 1'b1}, 1'b1);
        chk("shl_q_edge_k", {24'd0, q}, 32'hA5);
        chk("shl_busy_k", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("shl_q_step", {24'd0, q}, {24'd0, seq_q[i]});
            chk("shl_so_step", {31'd0, ser_out}, {31'd0, seq_so[i]});
            chk("shl_busy_step", {31'd0, busy}, (i < 2) ? 32'd1 : 32'd0);
            chk("shl_done_step", {31'd0, done}, (i == 2) ? 32'd1 : 32'd0);
        end
        ser_in = 1'b0;

        issue(LOAD, 8'h81, 4'd0, 1'b0, {8'h81, 1'b1}, 1'b1);
        wait_done("load81a");
        issue(ROR, 8'h00, 4'd1, 1'b0, {8'hC0, 1'b1}, 1'b1);
        wait_done("ror1");
        issue(LOAD, 8'h81, 4'd0, 1'b0, {8'h81, 1'b1}, 1'b1);
        wait_done("load81b");
        issue(ROR, 8'h00, 4'd8, 1'b0, {8'h81, 1'b1}, 1'b1);
        wait_done("ror8");
        issue(ROL, 8'h00, 4'd9, 1'b0, {8'h03, 1'b1}, 1'b1);
        wait_done("rol9");

        issue(LOAD, 8'h90, 4'd0, 1'b0, {8'h90, 1'b1}, 1'b1);
        wait_done("load90");
        issue(ASR, 8'h00, 4'd2, 1'b0, {8'hE4, 1'b0}, 1'b1);
        start = 1'b1;
        mode  = CLEAR;
        @(negedge clk);
        start = 1'b0;
        chk("asr_busy_mid", {31'd0, busy}, 32'd1);
        wait_done("asr2");

        issue(LOAD, 8'h3C, 4'd0, 1'b0, {8'h3C, 1'b0}, 1'b1);
        wait_done("load3c");
        issue(SHR, 8'h00, 4'd0, 1'b1, {8'h3C, 1'b0}, 1'b1);
        chk("shr0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("shr0_done", {31'd0, done}, 32'd1);
        chk("shr0_busy_low", {31'd0, busy}, 32'd0);

        issue(LOAD, 8'hFF, 4'd0, 1'b0, {8'hFF, 1'b0}, 1'b1);
        wait_done("loadff");
        issue(SHL, 8'h00, 4'd15, 1'b0, 9'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_q_pre", {24'd0, q}, 32'hF0);
        chk("abort_so_pre", {31'd0, ser_out}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_q", {24'd0, q}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_busy_after", {31'd0, busy}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
